countdown_timer_bcd: RTL

Parametrised BCD countdown timer: a prescaler turns the system clock into a tick, and a DIGITS-wide BCD down-counter counts ticks toward zero. Start, pause, load and one-shot or auto-reload modes are under control of the game/control FSM. It drives one 7-segment display per digit and flags expiry. It is the next-generation timer for the project top level and replaces the fixed 2-digit, fixed-preset timer.

---
 rtl/timer_pkg.sv | 28 ++
 rtl/bcd_digit_down.sv | 27 ++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/countdown_timer_bcd.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared state encoding, 7-segment glyphs and digit helpers for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } timer_state_t;

  // Active-low glyphs, bit order g..a
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
    return (digit > 4'd9) ? 4'd9 : digit;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; digits chain through borrow_in/borrow_out.
module bcd_digit_down #(
  parameter logic [3:0] RESET_DIGIT = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic [3:0] digit_q,
  output logic       borrow_out
);

  assign borrow_out = borrow_in && (digit_q == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= RESET_DIGIT;
    end else if (load) begin
      digit_q <= load_digit;
    end else if (dec_en && borrow_in) begin
      digit_q <= (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low 7-segment decoder; non-BCD codes blank the display.
module bcd_to_seg
  import timer_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// Prescaled multi-digit BCD countdown timer with pause, load and auto-reload,
// driving one active-low 7-segment display per digit.
module countdown_timer_bcd
  import timer_pkg::*;
#(
  parameter int unsigned         TICK_DIV    = 50_000_000,
  parameter int unsigned         DIGITS      = 2,
  parameter logic [4*DIGITS-1:0] RESET_VALUE = 'h30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  auto_reload,
  output logic [4*DIGITS-1:0]   count_q,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  t0,
  output logic                  expired,
  output logic                  running
);

  localparam int unsigned CW      = 4 * DIGITS;
  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [CW-1:0]      COUNT_ONE = CW'(1);

  timer_state_t        state, state_next;
  logic [PRESC_W-1:0]  presc, presc_next;
  logic [CW-1:0]       reload_reg, reload_next;
  logic                t0_next;
  logic                count_load;
  logic [CW-1:0]       count_load_val;
  logic                count_dec;
  logic [CW-1:0]       sat_value;
  logic [DIGITS:0]     borrow;
  logic                tick;
  logic                count_is_zero;
  logic                count_is_one;
  logic                reload_nonzero;

  always_comb begin
    sat_value = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sat_value[4*i +: 4] = bcd_sat(load_value[4*i +: 4]);
    end
  end

  // With borrow[0] tied high the chain's final borrow is set only when every digit is 0
  assign borrow[0]      = 1'b1;
  assign count_is_zero  = borrow[DIGITS];
  assign count_is_one   = (count_q == COUNT_ONE);
  assign reload_nonzero = (reload_reg != '0);
  assign tick           = (state == RUN) && (presc == PRESC_MAX);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_down #(
      .RESET_DIGIT(RESET_VALUE[4*i +: 4])
    ) u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (count_load),
      .load_digit (count_load_val[4*i +: 4]),
      .dec_en     (count_dec),
      .borrow_in  (borrow[i]),
      .digit_q    (count_q[4*i +: 4]),
      .borrow_out (borrow[i+1])
    );

    bcd_to_seg u_seg (
      .digit (count_q[4*i +: 4]),
      .seg   (seg[7*i +: 7])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      presc      <= '0;
      reload_reg <= RESET_VALUE;
      t0         <= 1'b0;
    end else begin
      state      <= state_next;
      presc      <= presc_next;
      reload_reg <= reload_next;
      t0         <= t0_next;
    end
  end

  always_comb begin
    state_next     = state;
    presc_next     = presc;
    reload_next    = reload_reg;
    t0_next        = 1'b0;
    count_load     = 1'b0;
    count_load_val = reload_reg;
    count_dec      = 1'b0;

    if (load) begin
      count_load     = 1'b1;
      count_load_val = sat_value;
      reload_next    = sat_value;
      presc_next     = '0;
      state_next     = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = RUN;
            presc_next = '0;
          end
        end
        PAUSED: begin
          if (start) begin
            state_next = RUN;
          end
        end
        EXPIRED: begin
          if (start) begin
            state_next = RUN;
            presc_next = '0;
            count_load = 1'b1;
          end
        end
        RUN: begin
          presc_next = tick ? '0 : presc + 1'b1;
          // A zero count in RUN only comes from a start at zero and resolves without a tick
          if (count_is_zero) begin
            t0_next = 1'b1;
            if (auto_reload && reload_nonzero) begin
              count_load = 1'b1;
            end else begin
              state_next = EXPIRED;
            end
          end else if (tick) begin
            if (auto_reload && reload_nonzero && count_is_one) begin
              count_load = 1'b1;
              t0_next    = 1'b1;
            end else begin
              count_dec = 1'b1;
              if (count_is_one) begin
                t0_next    = 1'b1;
                state_next = EXPIRED;
              end
            end
          end
          if (pause && state_next == RUN) begin
            state_next = PAUSED;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign expired = (state == EXPIRED);
  assign running = (state == RUN);

endmodule
